// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 800x600@60 Hz raster path.
`timescale 1ns/1ps
package vga_pkg;

    localparam int SVGA_H_VIS  = 800;
    localparam int SVGA_H_FP   = 40;
    localparam int SVGA_H_SYNC = 128;
    localparam int SVGA_H_BP   = 88;
    localparam int SVGA_V_VIS  = 600;
    localparam int SVGA_V_FP   = 1;
    localparam int SVGA_V_SYNC = 4;
    localparam int SVGA_V_BP   = 23;

    localparam int SVGA_H_TOT = SVGA_H_VIS + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
    localparam int SVGA_V_TOT = SVGA_V_VIS + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Sync flags are carried active-high; pin polarity is applied at the output register.
    typedef struct packed {
        logic hs;
        logic vs;
        logic visible;
    } sync_bundle_t;

endpackage

// File: rtl/vga_delay_line.sv
// Delays the {hs, vs, visible} bundle so it lines up with late-arriving pixel colour.
`timescale 1ns/1ps
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 0
)
(
    input  logic         clock,
    input  logic         reset,
    input  sync_bundle_t bundle,
    output sync_bundle_t delayed
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ports;
            assign unused_ports = clock ^ reset;
            assign delayed      = bundle;
        end else begin : g_shift
            sync_bundle_t stages [DEPTH];

            // Cleared stages read as blanked with both syncs inactive.
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= '0;
                    end
                end else begin
                    stages[0] <= bundle;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign delayed = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter for the display path: presents visible coordinates and a
// per-frame pulse, then registers returned colour with aligned sync/blank.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS    = SVGA_H_VIS,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_VIS    = SVGA_V_VIS,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter int SYNC_POS = 1,
    parameter int RGB_LAT  = 0
)
(
    input  logic               clock,
    input  logic               reset,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               visible,
    output logic               frame_done,
    input  logic [7:0]         red_in,
    input  logic [7:0]         green_in,
    input  logic [7:0]         blue_in,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    localparam logic SYNC_ACT = (SYNC_POS != 0);

    logic [10:0]  h_cnt;
    logic [9:0]   v_cnt;
    sync_bundle_t raw_sync;
    sync_bundle_t delayed_sync;
    rgb_t         pix_in;
    rgb_t         pix_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // h_cnt runs past 1023, so coordinates are gated rather than truncated.
    always_comb begin
        visible    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        col        = visible ? h_cnt[COORD_W-1:0] : '0;
        row        = visible ? v_cnt : '0;
        frame_done = (h_cnt == 11'd0) && (v_cnt == V_VIS_C);

        raw_sync.hs      = (h_cnt >= HS_START) && (h_cnt < HS_END);
        raw_sync.vs      = (v_cnt >= VS_START) && (v_cnt < VS_END);
        raw_sync.visible = visible;
    end

    vga_delay_line #(
        .DEPTH (RGB_LAT)
    ) u_delay (
        .clock   (clock),
        .reset   (reset),
        .bundle  (raw_sync),
        .delayed (delayed_sync)
    );

    assign pix_in = '{r: red_in, g: green_in, b: blue_in};

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_out     <= '0;
            vga_hs      <= ~SYNC_ACT;
            vga_vs      <= ~SYNC_ACT;
            vga_blank_n <= 1'b0;
        end else begin
            pix_out     <= delayed_sync.visible ? pix_in : '0;
            vga_hs      <= delayed_sync.hs ? SYNC_ACT : ~SYNC_ACT;
            vga_vs      <= delayed_sync.vs ? SYNC_ACT : ~SYNC_ACT;
            vga_blank_n <= delayed_sync.visible;
        end
    end

    assign vga_r      = pix_out.r;
    assign vga_g      = pix_out.g;
    assign vga_b      = pix_out.b;
    assign vga_sync_n = 1'b0;
    assign vga_clk    = clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing with RGB_LAT=2, plus a shrunken raster
// (active-low sync, RGB_LAT=0) to reach frame pulses, wrap and mid-frame reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a, reset_b;
    logic [9:0] row_a, col_a, row_b, col_b;
    logic       visible_a, frame_done_a, visible_b, frame_done_b;
    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic [7:0] vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
    logic       vga_hs_a, vga_vs_a, vga_blank_n_a, vga_sync_n_a, vga_clk_a;
    logic       vga_hs_b, vga_vs_b, vga_blank_n_b, vga_sync_n_b, vga_clk_b;

    int check_count = 0;
    int fail_count  = 0;

    vga_timing_gen #(
        .SYNC_POS (1),
        .RGB_LAT  (2)
    ) dut_a (
        .clock       (clock),
        .reset       (reset_a),
        .row         (row_a),
        .col         (col_a),
        .visible     (visible_a),
        .frame_done  (frame_done_a),
        .red_in      (red_a),
        .green_in    (green_a),
        .blue_in     (blue_a),
        .vga_r       (vga_r_a),
        .vga_g       (vga_g_a),
        .vga_b       (vga_b_a),
        .vga_hs      (vga_hs_a),
        .vga_vs      (vga_vs_a),
        .vga_blank_n (vga_blank_n_a),
        .vga_sync_n  (vga_sync_n_a),
        .vga_clk     (vga_clk_a)
    );

    vga_timing_gen #(
        .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VIS (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POS (0),
        .RGB_LAT  (0)
    ) dut_b (
        .clock       (clock),
        .reset       (reset_b),
        .row         (row_b),
        .col         (col_b),
        .visible     (visible_b),
        .frame_done  (frame_done_b),
        .red_in      (red_b),
        .green_in    (green_b),
        .blue_in     (blue_b),
        .vga_r       (vga_r_b),
        .vga_g       (vga_g_b),
        .vga_b       (vga_b_b),
        .vga_hs      (vga_hs_b),
        .vga_vs      (vga_vs_b),
        .vga_blank_n (vga_blank_n_b),
        .vga_sync_n  (vga_sync_n_b),
        .vga_clk     (vga_clk_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic bit pixel_visible(input int p, input int hv, input int ht, input int vv, input int vt);
        int q;
        if (p < 0) return 1'b0;
        q = p % (ht * vt);
        return ((q % ht) < hv) && ((q / ht) < vv);
    endfunction

    // Visible pixels get a pattern keyed to the pixel index; blanking gets white.
    function automatic logic [23:0] colour_for(input int p, input bit vis);
        logic [7:0] pb;
        pb = 8'(p);
        return vis ? {pb, pb ^ 8'h3C, 8'hC3} : 24'hFFFFFF;
    endfunction

    task automatic applyStimulus(input bit target_b, input logic [23:0] colour);
        if (target_b) {red_b, green_b, blue_b} = colour;
        else          {red_a, green_a, blue_a} = colour;
    endtask

    task automatic check_pixel(
        input string id, input int c, input int lat,
        input int hv, input int hfp, input int hsw, input int hbp,
        input int vv, input int vfp, input int vsw, input int vbp,
        input bit sync_pos,
        input logic [9:0] row, input logic [9:0] col,
        input logic vis, input logic fd,
        input logic hs, input logic vs, input logic blank_n,
        input logic [23:0] rgb
    );
        int ht, vt, q, h, v, p, ph, pv;
        bit exp_vis, pin_vis, raw_hs, raw_vs;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        q  = c % (ht * vt);
        h  = q % ht;
        v  = q / ht;
        exp_vis = (h < hv) && (v < vv);
        checkOutput($sformatf("%s.visible@%0d", id, c), 32'(vis), 32'(exp_vis));
        checkOutput($sformatf("%s.col@%0d", id, c), 32'(col), exp_vis ? 32'(h) : 32'd0);
        checkOutput($sformatf("%s.row@%0d", id, c), 32'(row), exp_vis ? 32'(v) : 32'd0);
        checkOutput($sformatf("%s.frame_done@%0d", id, c), 32'(fd), 32'((h == 0) && (v == vv)));

        p = c - lat - 1;
        raw_hs = 1'b0;
        raw_vs = 1'b0;
        pin_vis = 1'b0;
        if (p >= 0) begin
            q  = p % (ht * vt);
            ph = q % ht;
            pv = q / ht;
            raw_hs  = (ph >= hv + hfp) && (ph < hv + hfp + hsw);
            raw_vs  = (pv >= vv + vfp) && (pv < vv + vfp + vsw);
            pin_vis = (ph < hv) && (pv < vv);
        end
        checkOutput($sformatf("%s.vga_hs@%0d", id, c), 32'(hs), 32'(raw_hs ? sync_pos : !sync_pos));
        checkOutput($sformatf("%s.vga_vs@%0d", id, c), 32'(vs), 32'(raw_vs ? sync_pos : !sync_pos));
        checkOutput($sformatf("%s.vga_blank_n@%0d", id, c), 32'(blank_n), 32'(pin_vis));
        checkOutput($sformatf("%s.vga_rgb@%0d", id, c), 32'(rgb), pin_vis ? 32'(colour_for(p, 1'b1)) : 32'd0);
    endtask

    localparam int A_CYCLES = 3 * 1056 + 8;

    initial begin
        $display("[TB] start");
        reset_a = 1'b1;
        reset_b = 1'b1;
        applyStimulus(1'b0, 24'hFFFFFF);
        applyStimulus(1'b1, 24'hFFFFFF);
        repeat (3) @(posedge clock);

        // Full-size raster: three lines cover sync width, blanking and cols past 1023.
        @(negedge clock);
        reset_a = 1'b0;
        for (int c = 0; c < A_CYCLES; c++) begin
            if (c > 0) @(negedge clock);
            check_pixel("A", c, 2, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1,
                        row_a, col_a, visible_a, frame_done_a,
                        vga_hs_a, vga_vs_a, vga_blank_n_a, {vga_r_a, vga_g_a, vga_b_a});
            applyStimulus(1'b0, colour_for(c - 2, pixel_visible(c - 2, 800, 1056, 600, 628)));
        end
        checkOutput("A.vga_sync_n", 32'(vga_sync_n_a), 32'd0);
        checkOutput("A.vga_clk_low", 32'(vga_clk_a), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("A.vga_clk_high", 32'(vga_clk_a), 32'd1);

        // Small raster: run to line 3 pixel 4, pulse reset for one clock.
        @(negedge clock);
        reset_b = 1'b0;
        for (int c = 0; c <= 52; c++) begin
            if (c > 0) @(negedge clock);
            check_pixel("B0", c, 0, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0,
                        row_b, col_b, visible_b, frame_done_b,
                        vga_hs_b, vga_vs_b, vga_blank_n_b, {vga_r_b, vga_g_b, vga_b_b});
            applyStimulus(1'b1, colour_for(c, pixel_visible(c, 8, 16, 6, 11)));
        end
        reset_b = 1'b1;
        @(negedge clock);
        reset_b = 1'b0;

        // Restarted raster: two frame pulses, vertical sync and the full wrap.
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clock);
            check_pixel("B1", c, 0, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0,
                        row_b, col_b, visible_b, frame_done_b,
                        vga_hs_b, vga_vs_b, vga_blank_n_b, {vga_r_b, vga_g_b, vga_b_b});
            applyStimulus(1'b1, colour_for(c, pixel_visible(c, 8, 16, 6, 11)));
        end
        checkOutput("B.vga_sync_n", 32'(vga_sync_n_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the 800x600@60 Hz display path. Scans an 1056x628 pixel grid at one pixel per clock and presents visible coordinates (`row`, `col`) plus a once-per-frame `frame_done` pulse to the pixel-generation logic (background, paddles, ball). It also registers the returned RGB and drives the VGA/DAC pins with sync and blanking aligned to that RGB.

## Interface
- `H_VIS`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (clocks)
- `H_SYNC`, 128, horizontal sync width
- `H_BP`, 88, horizontal back porch
- `V_VIS`, 600, visible lines
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width
- `V_BP`, 23, vertical back porch
- `SYNC_POS`, 1, 1 = sync pulses active-high, 0 = active-low
- `RGB_LAT`, 0, clocks from `row`/`col` to valid `red_in`/`green_in`/`blue_in` (0..4)
- `clock` in 1: 40 MHz pixel clock.
- `reset` in 1: synchronous, active-high.
- `row` out 10: current visible line, 0..V_VIS-1; forced to 0 outside the visible area.
- `col` out 10: current visible pixel, 0..H_VIS-1; forced to 0 outside the visible area.
- `visible` out 1: `row`/`col` refer to an on-screen pixel.
- `frame_done` out 1: one-clock pulse at the start of vertical blanking.
- `red_in`, `green_in`, `blue_in` in 8 each: pixel colour, valid `RGB_LAT` clocks after the matching `row`/`col`.
- `vga_r`, `vga_g`, `vga_b` out 8 each: colour to the DAC.
- `vga_hs`, `vga_vs` out 1: sync outputs.
- `vga_blank_n` out 1: DAC blank, low outside the visible area.
- `vga_sync_n` out 1: tied to 0 (no sync-on-green).
- `vga_clk` out 1: forwarded copy of `clock`.

## Operation
- `h_cnt` is 11 bits and counts 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 1056. It wraps to 0.
- `v_cnt` is 10 bits and counts 0..V_TOT-1, where V_TOT = 628. It increments only when `h_cnt` wraps, and wraps to 0 when `h_cnt` wraps on line V_TOT-1.
- `visible` = (`h_cnt` < H_VIS) && (`v_cnt` < V_VIS).
- When `visible` is 1: `col` = `h_cnt`[9:0] and `row` = `v_cnt`.
- When `visible` is 0: `row` and `col` are both 0. `h_cnt` can exceed 1023, so `col` must never show a truncated count.
- Raw hsync is active for H_VIS+H_FP ≤ `h_cnt` < H_VIS+H_FP+H_SYNC.
- Raw vsync is active for V_VIS+V_FP ≤ `v_cnt` < V_VIS+V_FP+V_SYNC.
- Output polarity of both syncs is set by `SYNC_POS`.
- `frame_done` = 1 exactly when `h_cnt` = 0 and `v_cnt` = V_VIS: once per frame, one clock. Consumers update per-frame state (cloud positions, ball) on it.
- Output stage:
  - Raw hsync, vsync and `visible` pass through an `RGB_LAT`-deep delay line.
  - They are then registered together with `red_in`/`green_in`/`blue_in` into `vga_*`.
  - If the delayed `visible` is 0, the registered colour is 0x000000.
- Reset (synchronous; an assertion mid-frame behaves the same):
  - `h_cnt` and `v_cnt` = 0.
  - `row`, `col` = 0; `visible` = 1; `frame_done` = 0.
  - `vga_r`/`vga_g`/`vga_b` = 0.
  - `vga_hs`/`vga_vs` = inactive level; `vga_blank_n` = 0.
  - All delay-line stages cleared to not-visible / sync-inactive.
  - The first clock after reset deasserts presents pixel (0,0).

## Timing
- `row`, `col`, `visible` and `frame_done` are combinational from the counter registers and change on the clock edge.
- Pin latency is RGB_LAT+1 clocks: colour, sync and blank on the `vga_*` pins all belong to the `row`/`col` presented RGB_LAT+1 clocks earlier.
- Line period is 1056 clocks; frame period is 663,168 clocks.
- `frame_done` spacing is exactly 663,168 clocks.

## Structure
- Package `vga_pkg` holds:
  - the 800x600 timing constants and derived H_TOT/V_TOT;
  - `typedef struct packed {logic [7:0] r, g, b;} rgb_t`;
  - the coordinate width constant (10).
- One sub-module, `vga_delay_line`: a parameterised-depth shift register for the {hs, vs, visible} bundle, with depth-0 pass-through.

## Test plan
- **Reset, then free run:** first post-reset cycle shows `row`=0, `col`=0, `visible`=1; `col` reaches 799 at clock 799, and at clock 800 `visible`=0 and `col`=0.
- **Horizontal sync:** `vga_hs` active for clocks 840..967 of each line (shifted by RGB_LAT+1 at the pin), exactly 128 clocks.
- **Vertical sync and frame pulse:**
  - `frame_done` pulses once at line 600, clock 0.
  - `vga_vs` is active on lines 601..604.
  - Next `frame_done` arrives 663,168 clocks later.
- **Alignment, RGB_LAT=2:** drive `red_in` = `col`[7:0] delayed by 2; pins show `vga_r` = 0x05 exactly 3 clocks after `col`=5. During blanking `vga_r`=0 even with `red_in`=0xFF.
- **Mid-frame reset:** assert `reset` at line 300, pixel 400 for one clock. The next cycle shows (0,0), `frame_done` stays 0 until line 600, and no partial sync pulse appears.
- **Wrap:** at `h_cnt`=1055, `v_cnt`=627 the next clock gives `row`=0, `col`=0, `visible`=1; `col` never shows values 1024..1055.
